// File: rtl/fft_result_uart_tx.sv
// fft_result_uart_tx
// Collects one frame of N complex FFT results into a 2N-entry buffer (Re at
// even, Im at odd entries). Once the frame is full it converts each entry to
// one signed byte and sends it over a UART 8N1 line, Re then Im per sample,
// in arrival order.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   Re_i     signed real part of the incoming sample
//   Im_i     signed imaginary part of the incoming sample
//   en_i     one-cycle valid strobe for Re_i/Im_i (ignored unless ready_o)
//   ready_o  high while a sample can be accepted
//   busy_o   high while the frame is being transmitted
//   tx_o     UART serial output, idle high, registered
//   done_o   one-cycle pulse after the last stop bit of a frame
//
// Build option:
//   FFT_TX_SATURATE_EN  defined: byte = clamp(sample >>> FRAC_SHIFT, -128, 127)
//                       undefined: byte = low 8 bits of sample >>> FRAC_SHIFT
//
// Top FSM states:
//   state      | meaning
//   COLLECT    | accept samples until N are buffered
//   LOAD_BYTE  | convert entry rd_ptr and start the UART engine (1 cycle)
//   SEND       | wait for the engine's byte-done
//   DONE       | pulse done_o, clear pointers
//
// UART engine states:
//   state  | meaning
//   IDLE   | line high, waiting for start
//   START  | start bit (low)
//   DATA   | 8 data bits, LSB first
//   STOP   | stop bit (high)

module fft_result_uart_tx #(
  parameter int          bit_width    = 32,
  parameter int          N            = 16,
  parameter int          SIZE         = 4,
  parameter int          FRAC_SHIFT   = 6,
  parameter logic [15:0] t_1_bit      = 16'd5207,
  parameter logic [15:0] t_half_1_bit = 16'd2603
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [bit_width-1:0] Re_i,
  input  logic signed [bit_width-1:0] Im_i,
  input  logic                        en_i,
  output logic                        ready_o,
  output logic                        busy_o,
  output logic                        tx_o,
  output logic                        done_o
);

  localparam int PTR_W = SIZE + 1;

  // Elaboration-time sanity checks on the parameter set.
  if (N != (1 << SIZE)) begin : g_bad_size
    $error("N must equal 2**SIZE");
  end
  if (t_half_1_bit >= t_1_bit) begin : g_bad_half_bit
    $error("t_half_1_bit must be below t_1_bit");
  end

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [PTR_W-1:0] WR_LAST   = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] RD_LAST   = PTR_W'(2 * N - 1);
  localparam logic [15:0]      BIT_RELOAD = t_1_bit - 16'd1;

  // --------------------------------------------------------------------------
  // Top FSM and pointers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             start_byte;
  logic             byte_done;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_en      = 1'b0;
    start_byte = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (en_i) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          // Leaving on the N-th strobe makes ready_o drop the following cycle.
          if (wr_ptr_q == WR_LAST) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        start_byte = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (byte_done) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = (rd_ptr_q == RD_LAST) ? S_DONE : S_LOAD;
        end
      end
      default: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        state_d  = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign ready_o = (state_q == S_COLLECT);
  assign busy_o  = (state_q == S_LOAD) || (state_q == S_SEND);
  assign done_o  = (state_q == S_DONE);

  // --------------------------------------------------------------------------
  // Frame buffer (contents need no reset)
  // --------------------------------------------------------------------------
  logic [bit_width-1:0] mem_q [2*N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_ptr_q[SIZE-1:0], 1'b0}] <= Re_i;
      mem_q[{wr_ptr_q[SIZE-1:0], 1'b1}] <= Im_i;
    end
  end

  // --------------------------------------------------------------------------
  // Byte conversion
  // --------------------------------------------------------------------------
  logic signed [bit_width-1:0] sample_sel;
  logic signed [bit_width-1:0] sample_shr;
  logic [7:0]                  tx_byte;

  assign sample_sel = mem_q[rd_ptr_q];
  assign sample_shr = sample_sel >>> FRAC_SHIFT;

`ifdef FFT_TX_SATURATE_EN
  localparam logic signed [bit_width-1:0] SAT_HI = bit_width'(127);
  localparam logic signed [bit_width-1:0] SAT_LO = -(bit_width'(128));

  always_comb begin
    if (sample_shr > SAT_HI)      tx_byte = 8'h7F;
    else if (sample_shr < SAT_LO) tx_byte = 8'h80;
    else                          tx_byte = 8'(sample_shr);
  end
`else
  // Upper bits are dropped silently; wraparound is intended.
  assign tx_byte = 8'(sample_shr);
`endif

  // --------------------------------------------------------------------------
  // UART 8N1 engine; bit timer is a down-counter reloaded per bit
  // --------------------------------------------------------------------------
  logic [1:0]  u_state_q, u_state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;

  assign byte_done = (u_state_q == U_STOP) && (bit_cnt_q == 16'd0);

  always_comb begin
    u_state_d = u_state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    case (u_state_q)
      U_IDLE: begin
        if (start_byte) begin
          u_state_d = U_START;
          tx_d      = 1'b0;
          bit_cnt_d = BIT_RELOAD;
          bit_idx_d = 3'd0;
          shreg_d   = tx_byte;
        end
      end
      U_START: begin
        if (bit_cnt_q == 16'd0) begin
          u_state_d = U_DATA;
          tx_d      = shreg_q[0];
          bit_cnt_d = BIT_RELOAD;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      U_DATA: begin
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = BIT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            u_state_d = U_STOP;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: begin
        if (bit_cnt_q == 16'd0) u_state_d = U_IDLE;
        else                    bit_cnt_d = bit_cnt_q - 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_state_q <= U_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      u_state_q <= u_state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule
